mem_access_unit: RTL and testbench

Load/store unit directly downstream of the CPU datapath. Takes the datapath's ALU result as the effective address and its register-file read data as store data. Runs a req/ack transaction on the data-memory bus and stalls the datapath while the transaction is outstanding. Returns byte/halfword-aligned, sign- or zero-extended load data on the datapath's `Data_in` input.

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/load_align.sv | 36 +++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the load/store path: funct3 size/sign codes (also used
// by the controller decoder), FSM state encodings and byte-enable patterns.
package mem_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unknown funct3 codes fall through to a word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the addressed byte/half out of a raw bus
// word and sign- or zero-extends it. Word codes pass the raw word through.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_unsigned;

  assign is_unsigned = funct3[2];

  // Lane select and extension; half accesses only look at addr_lo[1].
  always_comb begin
    byte_sel = raw[7:0];
    half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    rdata    = raw;
    case (addr_lo)
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    case (f3_size(funct3))
      SZ_BYTE: rdata = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU datapath and the data-memory req/ack bus.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses are
// completed without a bus transaction and flagged on the misaligned port.
//
// state   | meaning
// IDLE    | waiting for mem_read/mem_write; request cycle stalls combinationally
// REQ     | bus_req high, waiting for bus_ack or timeout
// DONE    | one-cycle completion, rdata valid, always back to IDLE
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misaligned,
`endif
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_e      state_q, state_d;
  size_e       size_in;
  logic        req_in;
  logic        trap_cond;
  logic        take, trap, ack_hit, tmo;
  logic [15:0] cnt_q;
  logic [16:0] cnt_inc;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] load_data;

  assign req_in  = mem_read | mem_write;
  assign size_in = f3_size(funct3);
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign trap_cond  = is_misaligned(size_in, addr[1:0]);
  assign misaligned = mis_q;

  // Trap flag is only ever set on the edge into DONE, so it reads as a pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_q <= 1'b0;
    else      mis_q <= trap;
  end
`else
  assign trap_cond = 1'b0;
`endif

  // State register; reset drops bus_req immediately since it decodes from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and transition strobes.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    trap    = 1'b0;
    ack_hit = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          take = 1'b1;
          if (trap_cond) begin
            trap    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          ack_hit = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_inc == 17'(ACK_TIMEOUT)) begin
          tmo     = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte enables and lane replication for the incoming access.
  always_comb begin
    be_d    = BE_WORD;
    wdata_d = wdata;
    unique case (size_in)
      SZ_BYTE: begin
        be_d    = BE_BYTE0 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_d    = addr[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = BE_WORD;
        wdata_d = wdata;
      end
    endcase
  end

  load_align u_load_align (
    .raw     (bus_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .rdata   (load_data)
  );

  // Access latch, timeout counter, completion flags and load data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      addr_lo_q <= '0;
      f3_q      <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        bus_addr  <= {addr[31:2], 2'b00};
        bus_be    <= be_d;
        bus_wdata <= wdata_d;
        bus_we    <= mem_write;
        addr_lo_q <= addr[1:0];
        f3_q      <= funct3;
        cnt_q     <= '0;
      end else if (state_q == ST_REQ && !bus_ack) begin
        cnt_q <= cnt_inc[15:0];
      end
      err_q <= tmo;
      if (ack_hit && !bus_we) rdata_q <= load_data;
      else if (tmo || trap)   rdata_q <= '0;
    end
  end

  assign bus_req = (state_q == ST_REQ);
  assign done    = (state_q == ST_DONE);
  assign bus_err = err_q;
  assign rdata   = rdata_q;
  assign stall   = ((state_q == ST_IDLE) && req_in) || (state_q == ST_REQ);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit, built with ACK_TIMEOUT=4.
module tb_mem_access_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, done, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int passed = 0;
  int total  = 0;
  int done_cnt = 0;

  mem_access_unit #(.ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .done(done), .bus_err(bus_err),
`ifdef MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from an IDLE cycle (+1 after edge) and observes it until
  // done (bounded). waits<0 withholds ack. Returns at +2 in the DONE cycle.
  task automatic run_access(
    input  logic        we, input logic [2:0] f3, input logic [31:0] a,
    input  logic [31:0] wd, input logic [31:0] rd, input int waits,
    output int lat, output int nstall, output int nreq,
    output logic [31:0] rd_o, output logic err_o, output logic mis_o,
    output logic [3:0] be_o, output logic [31:0] wd_o, output logic [31:0] addr_o,
    output logic we_o);
    int rc;
    mem_read = !we; mem_write = we; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = rd; bus_ack = 1'b0;
    lat = 0; nstall = 0; nreq = 0; rc = 0;
    rd_o = 'x; err_o = 1'bx; mis_o = 1'b0;
    be_o = '0; wd_o = '0; addr_o = '0; we_o = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      #1;
      if (stall === 1'b1) nstall++;
      if (done === 1'b1) begin
        lat = c; rd_o = rdata; err_o = bus_err;
`ifdef MISALIGN_TRAP_EN
        mis_o = misaligned;
`endif
        break;
      end
      if (bus_req === 1'b1) begin
        nreq++;
        be_o = bus_be; wd_o = bus_wdata; addr_o = bus_addr; we_o = bus_we;
        bus_ack = (waits >= 0 && rc == waits);
        rc++;
      end
      @(posedge clk);
      #1;
    end
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({bus_req, bus_we, done, stall, bus_err} !== 5'b0) $display("FAIL reset_ctrl got %b want 00000", {bus_req, bus_we, done, stall, bus_err});
    else passed++;
    total++;
    if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else passed++;
    total++;
    if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || bus_be !== 4'd0)
      $display("FAIL reset_bus got addr=%h wdata=%h be=%b want zeros", bus_addr, bus_wdata, bus_be);
    else passed++;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_lw();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (lat != 3) $display("FAIL lw_latency got %0d want 3", lat); else passed++;
    total++; if (ns != 2) $display("FAIL lw_stall got %0d want 2", ns); else passed++;
    total++; if (r !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h want deadbeef", r); else passed++;
    total++; if (a_o !== 32'h100 || be !== 4'b1111 || w !== 1'b0)
      $display("FAIL lw_bus got addr=%h be=%b we=%b want 100 1111 0", a_o, be, w); else passed++;
    #1;
    total++; if (bus_req !== 1'b0) $display("FAIL lw_req_drop got %b want 0", bus_req); else passed++;
    step();
  endtask

  task automatic test_loads();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (r !== 32'hFFFFFF80) $display("FAIL lb_rdata got %h want ffffff80", r); else passed++;
    step();
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (r !== 32'h00000080) $display("FAIL lbu_rdata got %h want 00000080", r); else passed++;
    step();
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (r !== 32'hFFFF8001) $display("FAIL lh_rdata got %h want ffff8001", r); else passed++;
    total++; if (lat != 4 || ns != 3) $display("FAIL lh_wait_latency got lat=%0d stall=%0d want 4 3", lat, ns); else passed++;
    step();
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (r !== 32'h00008001) $display("FAIL lhu_rdata got %h want 00008001", r); else passed++;
    step();
  endtask

  task automatic test_stores();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    run_access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (be !== 4'b1100) $display("FAIL sh_be got %b want 1100", be); else passed++;
    total++; if (wd_o !== 32'hABCDABCD) $display("FAIL sh_wdata got %h want abcdabcd", wd_o); else passed++;
    total++; if (a_o !== 32'h100 || w !== 1'b1) $display("FAIL sh_addr_we got %h %b want 100 1", a_o, w); else passed++;
    total++; if (r !== 32'h00008001) $display("FAIL sh_rdata_hold got %h want 00008001", r); else passed++;
    step();
    run_access(1'b1, 3'b000, 32'h101, 32'hAAAA5577, 32'h0, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (be !== 4'b0010 || wd_o !== 32'h77777777)
      $display("FAIL sb_lanes got be=%b wdata=%h want 0010 77777777", be, wd_o); else passed++;
    step();
  endtask

  task automatic test_timeout();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    run_access(1'b0, 3'b010, 32'h40, 32'h0, 32'h55555555, -1, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (lat != 6 || nr != 4) $display("FAIL tmo_latency got lat=%0d req=%0d want 6 4", lat, nr); else passed++;
    total++; if (e !== 1'b1) $display("FAIL tmo_bus_err got %b want 1", e); else passed++;
    total++; if (r !== 32'd0) $display("FAIL tmo_rdata got %h want 0", r); else passed++;
    step();
    total++; if (bus_err !== 1'b0) $display("FAIL tmo_err_pulse got %b want 0", bus_err); else passed++;
    bus_ack = 1'b1;
    step(); step();
    total++; if (bus_req !== 1'b0 || done !== 1'b0 || rdata !== 32'd0)
      $display("FAIL late_ack got req=%b done=%b rdata=%h want 0 0 0", bus_req, done, rdata); else passed++;
    bus_ack = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
`ifdef MISALIGN_TRAP_EN
    total++; if (lat != 2 || nr != 0) $display("FAIL trap_latency got lat=%0d req=%0d want 2 0", lat, nr); else passed++;
    total++; if (m !== 1'b1 || r !== 32'd0) $display("FAIL trap_flag got mis=%b rdata=%h want 1 0", m, r); else passed++;
`else
    total++; if (lat != 3 || a_o !== 32'h100) $display("FAIL mis_word got lat=%0d addr=%h want 3 100", lat, a_o); else passed++;
    total++; if (r !== 32'h11223344) $display("FAIL mis_rdata got %h want 11223344", r); else passed++;
`endif
    step();
  endtask

  task automatic test_reset_mid_req();
    int lat, ns, nr; logic [31:0] r, wd_o, a_o; logic e, m, w; logic [3:0] be;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200; bus_ack = 1'b0;
    step();
    #1;
    total++; if (bus_req !== 1'b1) $display("FAIL rst_pre_req got %b want 1", bus_req); else passed++;
    bus_ack = 1'b1;
    #1 rst = 1'b0;
    #1;
    total++; if (bus_req !== 1'b0) $display("FAIL rst_req_drop got %b want 0", bus_req); else passed++;
    mem_read = 1'b0;
    step();
    total++; if (done !== 1'b0) $display("FAIL rst_no_done got %b want 0", done); else passed++;
    bus_ack = 1'b0;
    rst = 1'b1;
    step();
    done_cnt = 0;
    run_access(1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 0, lat, ns, nr, r, e, m, be, wd_o, a_o, w);
    total++; if (lat != 3 || be !== 4'b1111 || wd_o !== 32'hCAFEF00D)
      $display("FAIL sw_after_rst got lat=%0d be=%b wdata=%h want 3 1111 cafef00d", lat, be, wd_o); else passed++;
    step(); step(); step();
    total++; if (done_cnt != 1) $display("FAIL done_count got %0d want 1", done_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_timeout();
    test_misaligned();
    test_reset_mid_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
